unified_mem_responder: RTL

- Memory-side responder for the pipelined RISC-V core.
- Serves two initiators over req/ack handshakes from one single-ported, byte-addressed unified store:
  - the instruction-fetch port (IF stage);
  - the data load/store port (MEM stage).
- Arbitrates between the two ports and inserts programmable wait states.
- Performs RV32I byte, half and word sizing with sign or zero extension.

---
 rtl/unified_mem_responder.sv | 136 +++++++++++++
 1 files changed

// File: rtl/unified_mem_responder.sv
// unified_mem_responder: arbitrated fetch/data responder over one byte-addressed store with wait states and RV32I sizing
module unified_mem_responder #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 32,
  parameter int LAT    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_func3,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              busy
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic gnt_q, gnt_d, last_q, last_d, we_q, we_d, err_q, err_d;
  logic [2:0] f3_q, f3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0] wd_q, wd_d, if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic [7:0] mem [DEPTH];
  logic idle, pick_d, enter, c_we, err, misal, oor, bad_f3;
  logic [2:0] c_f3, size;
  logic [ADDR_W-1:0] c_addr;
  logic [ADDR_W:0] end_a;
  logic [31:0] c_wd, word, rd;
  logic [15:0] half;
  logic [7:0] byt;
  logic [AW-1:0] idx;
  // In IDLE the access is evaluated straight from the winning port so LAT=0 can commit on the grant edge
  always_comb begin
    idle   = state_q == IDLE;
    pick_d = d_req & (~if_req | ~last_q);
    c_addr = idle ? (pick_d ? d_addr : if_addr) : addr_q;
    c_we   = idle ? pick_d & d_we : we_q;
    c_f3   = idle ? (pick_d ? d_func3 : 3'b010) : f3_q;
    c_wd   = idle ? d_wdata : wd_q;
    size   = c_f3[1] ? 3'd4 : c_f3[0] ? 3'd2 : 3'd1;
    bad_f3 = (c_f3[1] & (c_f3[0] | c_f3[2])) | (c_we & c_f3[2]);
    misal  = (c_f3[0] & c_addr[0]) | (c_f3[1] & |c_addr[1:0]);
    end_a  = {1'b0, c_addr} + (ADDR_W+1)'(size);
    oor    = end_a > (ADDR_W+1)'(DEPTH);
    err    = bad_f3 | misal | oor;
    idx    = c_addr[AW-1:0];
    byt    = mem[idx];
    half   = {mem[idx + AW'(1)], mem[idx]};
    word   = {mem[idx + AW'(3)], mem[idx + AW'(2)], half};
    rd     = err ? 32'd0 : c_f3[1] ? word :
             c_f3[0] ? {{16{~c_f3[2] & half[15]}}, half} : {{24{~c_f3[2] & byt[7]}}, byt};
    enter  = (idle && (if_req | d_req) && LAT == 0) || (state_q == WAIT && cnt_q == 4'd0);
    state_d = state_q;
    cnt_d = cnt_q;
    gnt_d = gnt_q;
    last_d = last_q;
    addr_d = addr_q;
    we_d = we_q;
    f3_d = f3_q;
    wd_d = wd_q;
    err_d = err_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d = d_rdata_q;
    if (idle && (if_req | d_req)) begin
      state_d = (LAT == 0) ? RESP : WAIT;
      cnt_d = 4'(LAT - 1);
      gnt_d = pick_d;
      last_d = pick_d;
      addr_d = c_addr;
      we_d = c_we;
      f3_d = c_f3;
      wd_d = c_wd;
    end else if (state_q == WAIT) begin
      state_d = cnt_q == 4'd0 ? RESP : WAIT;
      cnt_d = cnt_q - 4'd1;
    end else if (state_q == RESP) begin
      state_d = IDLE;
    end
    if (enter) begin
      err_d = err;
      d_rdata_d = gnt_d ? rd : d_rdata_q;
      if_rdata_d = gnt_d ? if_rdata_q : rd;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      gnt_q <= 1'b0;
      last_q <= 1'b0;
      addr_q <= '0;
      we_q <= 1'b0;
      f3_q <= '0;
      wd_q <= '0;
      err_q <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      gnt_q <= gnt_d;
      last_q <= last_d;
      addr_q <= addr_d;
      we_q <= we_d;
      f3_q <= f3_d;
      wd_q <= wd_d;
      err_q <= err_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset && enter && c_we && !err) begin
      mem[idx] <= c_wd[7:0];
      if (c_f3[0] | c_f3[1]) mem[idx + AW'(1)] <= c_wd[15:8];
      if (c_f3[1]) mem[idx + AW'(2)] <= c_wd[23:16];
      if (c_f3[1]) mem[idx + AW'(3)] <= c_wd[31:24];
    end
  end
  assign busy = state_q != IDLE;
  assign if_ack = state_q == RESP && !gnt_q;
  assign d_ack = state_q == RESP && gnt_q;
  assign if_err = if_ack & err_q;
  assign d_err = d_ack & err_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata = d_rdata_q;
endmodule
